// File: rtl/xadac_dcache_mux.sv
// N-port round-robin arbiter onto a single dcache request port, with in-order
// response routing through an ID-tracking FIFO. Optional counters: XADAC_DCACHE_MUX_PERF_EN.
module xadac_dcache_mux #(
   parameter int unsigned NumPorts       = 2,
   parameter int unsigned AddrWidth      = 64,
   parameter int unsigned DataWidth      = 64,
   parameter int unsigned IdWidth        = 4,
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic [NumPorts-1:0]              req_valid_i,
   output logic [NumPorts-1:0]              req_ready_o,
   input  logic [NumPorts*AddrWidth-1:0]    req_addr_i,
   input  logic [NumPorts*DataWidth-1:0]    req_wdata_i,
   input  logic [NumPorts*DataWidth/8-1:0]  req_be_i,
   input  logic [NumPorts-1:0]              req_we_i,
   input  logic [NumPorts*IdWidth-1:0]      req_id_i,
   output logic [NumPorts-1:0]              rsp_valid_o,
   output logic [DataWidth-1:0]             rsp_rdata_o,
   output logic [IdWidth-1:0]               rsp_id_o,
   output logic                             dc_req_valid_o,
   input  logic                             dc_req_ready_i,
   output logic [AddrWidth-1:0]             dc_req_addr_o,
   output logic [DataWidth-1:0]             dc_req_wdata_o,
   output logic [DataWidth/8-1:0]           dc_req_be_o,
   output logic                             dc_req_we_o,
   input  logic                             dc_rsp_valid_i,
   input  logic [DataWidth-1:0]             dc_rsp_rdata_i,
   output logic                             err_o
`ifdef XADAC_DCACHE_MUX_PERF_EN
   ,
   output logic [NumPorts*32-1:0]           perf_grant_cnt_o,
   output logic [31:0]                      perf_full_stall_cnt_o
`endif
);

   localparam int unsigned BeWidth      = DataWidth / 8;
   localparam int unsigned CntWidth     = $clog2(MaxOutstanding + 1);
   localparam int unsigned PtrWidth     = (NumPorts > 1) ? $clog2(NumPorts) : 1;
   localparam int unsigned FifoPtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

   typedef struct packed {
      logic [PtrWidth-1:0] port;
      logic [IdWidth-1:0]  id;
   } trk_entry_t;

   typedef enum logic [0:0] {
      ST_ARB    = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_e;

   lock_state_e           state_q, state_d;
   logic [PtrWidth-1:0]   lock_idx_q, lock_idx_d;
   logic [PtrWidth-1:0]   rr_ptr_q;
   logic [CntWidth-1:0]   count_q;
   logic [FifoPtrWidth-1:0] wr_ptr_q, rd_ptr_q;
   trk_entry_t            trk_mem [MaxOutstanding];
   logic                  err_q;

   logic                  win_vld;
   logic [PtrWidth-1:0]   win_idx;
   logic [IdWidth-1:0]    win_id;
   logic                  issue_ok;
   logic                  accept;
   logic                  pop;
   trk_entry_t            head;
   int unsigned           cand;

   // Round-robin search from rr_ptr; a locked winner overrides the search
   always_comb begin
      win_vld = 1'b0;
      win_idx = rr_ptr_q;
      cand    = 0;
      if (state_q == ST_LOCKED) begin
         win_idx = lock_idx_q;
         win_vld = req_valid_i[lock_idx_q];
      end else begin
         for (int unsigned i = 0; i < NumPorts; i++) begin
            cand = (32'(rr_ptr_q) + i) % NumPorts;
            if (!win_vld && req_valid_i[PtrWidth'(cand)]) begin
               win_vld = 1'b1;
               win_idx = PtrWidth'(cand);
            end
         end
      end
   end

   assign issue_ok       = count_q < CntWidth'(MaxOutstanding);
   assign dc_req_valid_o = rstn & win_vld & issue_ok;
   assign accept         = dc_req_valid_o & dc_req_ready_i;

   // Zero-latency field mux from the winning port
   always_comb begin
      dc_req_addr_o  = '0;
      dc_req_wdata_o = '0;
      dc_req_be_o    = '0;
      dc_req_we_o    = 1'b0;
      win_id         = '0;
      req_ready_o    = '0;
      for (int unsigned i = 0; i < NumPorts; i++) begin
         if (win_idx == PtrWidth'(i)) begin
            dc_req_addr_o  = req_addr_i[i*AddrWidth +: AddrWidth];
            dc_req_wdata_o = req_wdata_i[i*DataWidth +: DataWidth];
            dc_req_be_o    = req_be_i[i*BeWidth +: BeWidth];
            dc_req_we_o    = req_we_i[i];
            win_id         = req_id_i[i*IdWidth +: IdWidth];
            req_ready_o[i] = accept;
         end
      end
   end

   assign head = trk_mem[rd_ptr_q];
   assign pop  = rstn & dc_rsp_valid_i & (count_q != '0);

   // Responses are steered to the port recorded at the FIFO head
   always_comb begin
      rsp_valid_o = '0;
      for (int unsigned i = 0; i < NumPorts; i++) begin
         rsp_valid_o[i] = pop & (head.port == PtrWidth'(i));
      end
   end

   assign rsp_id_o    = head.id;
   assign rsp_rdata_o = dc_rsp_rdata_i;
   assign err_o       = err_q;

   // Lock holds the presented port stable while the dcache stalls
   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      case (state_q)
         ST_ARB: begin
            if (dc_req_valid_o && !dc_req_ready_i) begin
               state_d    = ST_LOCKED;
               lock_idx_d = win_idx;
            end
         end
         ST_LOCKED: begin
            if (accept) state_d = ST_ARB;
         end
         default: state_d = ST_ARB;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_ARB;
         lock_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_idx_q <= lock_idx_d;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_ptr_q <= '0;
      end else if (accept) begin
         rr_ptr_q <= (win_idx == PtrWidth'(NumPorts - 1)) ? '0 : win_idx + PtrWidth'(1);
      end
   end

   // Tracking FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (accept && !pop)      count_q <= count_q + CntWidth'(1);
         else if (!accept && pop) count_q <= count_q - CntWidth'(1);
         if (accept) begin
            wr_ptr_q <= (wr_ptr_q == FifoPtrWidth'(MaxOutstanding - 1)) ? '0
                                                                          : wr_ptr_q + FifoPtrWidth'(1);
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == FifoPtrWidth'(MaxOutstanding - 1)) ? '0
                                                                          : rd_ptr_q + FifoPtrWidth'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         trk_mem[wr_ptr_q] <= '{port: win_idx, id: win_id};
      end
   end

   // Sticky flag for a dcache response with nothing outstanding
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_q <= 1'b0;
      end else if (dc_rsp_valid_i && (count_q == '0)) begin
         err_q <= 1'b1;
      end
   end

`ifdef XADAC_DCACHE_MUX_PERF_EN
   logic [31:0] grant_cnt_q [NumPorts];
   logic [31:0] full_stall_cnt_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < NumPorts; i++) grant_cnt_q[i] <= '0;
         full_stall_cnt_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NumPorts; i++) begin
            if (req_ready_o[i]) grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
         end
         if ((|req_valid_i) && (count_q == CntWidth'(MaxOutstanding))) begin
            full_stall_cnt_q <= full_stall_cnt_q + 32'd1;
         end
      end
   end

   always_comb begin
      perf_grant_cnt_o = '0;
      for (int unsigned i = 0; i < NumPorts; i++) begin
         perf_grant_cnt_o[i*32 +: 32] = grant_cnt_q[i];
      end
   end

   assign perf_full_stall_cnt_o = full_stall_cnt_q;
`endif

endmodule

// File: tb/tb_xadac_dcache_mux.sv
// Scoreboard bench for xadac_dcache_mux: two requesters, a small in-order dcache
// model, and expected responses queued at grant time.
module tb_xadac_dcache_mux;

   localparam int unsigned NP = 2;
   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;
   localparam int unsigned IW = 4;
   localparam int unsigned MO = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rstn;
   logic [NP-1:0]        req_valid_i;
   logic [NP-1:0]        req_ready_o;
   logic [NP*AW-1:0]     req_addr_i;
   logic [NP*DW-1:0]     req_wdata_i;
   logic [NP*DW/8-1:0]   req_be_i;
   logic [NP-1:0]        req_we_i;
   logic [NP*IW-1:0]     req_id_i;
   logic [NP-1:0]        rsp_valid_o;
   logic [DW-1:0]        rsp_rdata_o;
   logic [IW-1:0]        rsp_id_o;
   logic                 dc_req_valid_o;
   logic                 dc_req_ready_i;
   logic [AW-1:0]        dc_req_addr_o;
   logic [DW-1:0]        dc_req_wdata_o;
   logic [DW/8-1:0]      dc_req_be_o;
   logic                 dc_req_we_o;
   logic                 dc_rsp_valid_i;
   logic [DW-1:0]        dc_rsp_rdata_i;
   logic                 err_o;

   logic [AW-1:0]   addr_d  [NP];
   logic [IW-1:0]   id_d    [NP];
   logic            we_d    [NP];

   assign req_addr_i  = {addr_d[1], addr_d[0]};
   assign req_wdata_i = {~addr_d[1], ~addr_d[0]};
   assign req_be_i    = 16'hFFFF;
   assign req_we_i    = {we_d[1], we_d[0]};
   assign req_id_i    = {id_d[1], id_d[0]};

   xadac_dcache_mux #(
      .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .MaxOutstanding(MO)
   ) dut (
      .clk(clk), .rstn(rstn),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
      .req_we_i(req_we_i), .req_id_i(req_id_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_id_o(rsp_id_o),
      .dc_req_valid_o(dc_req_valid_o), .dc_req_ready_i(dc_req_ready_i),
      .dc_req_addr_o(dc_req_addr_o), .dc_req_wdata_o(dc_req_wdata_o),
      .dc_req_be_o(dc_req_be_o), .dc_req_we_o(dc_req_we_o),
      .dc_rsp_valid_i(dc_rsp_valid_i), .dc_rsp_rdata_i(dc_rsp_rdata_i),
      .err_o(err_o)
   );

   typedef struct packed {
      logic [63:0] addr;
      logic [3:0]  id;
      logic        we;
   } req_t;

   typedef struct packed {
      logic [31:0] port;
      logic [3:0]  id;
      logic [63:0] data;
   } exp_t;

   req_t        pq0[$];
   req_t        pq1[$];
   exp_t        sb[$];
   logic [63:0] dcq[$];
   int          grant_log[$];
   logic [NP-1:0] accepted;
   bit          rsp_auto;
   bit          rsp_once;
   int          n_checks;
   int          n_errors;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [63:0] dfn(input logic [63:0] a, input logic we);
      return we ? ~a : (a ^ 64'h5A5A_0000_F0F0_1234);
   endfunction

   task automatic load(input int k, input req_t r);
      req_valid_i[k] = 1'b1;
      addr_d[k]      = r.addr;
      id_d[k]        = r.id;
      we_d[k]        = r.we;
   endtask

   task automatic refill();
      for (int k = 0; k < NP; k++) begin
         if (accepted[k] || !req_valid_i[k]) begin
            req_valid_i[k] = 1'b0;
            if (k == 0 && pq0.size() > 0) load(0, pq0.pop_front());
            else if (k == 1 && pq1.size() > 0) load(1, pq1.pop_front());
         end
      end
      accepted = '0;
   endtask

   // Sample at the falling edge: responses first, then grants, then dcache model
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (dc_rsp_valid_i) begin
         if (dcq.size() > 0) void'(dcq.pop_front());
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_valid", 64'(rsp_valid_o), 64'(1) << e.port);
            chk("rsp_id", 64'(rsp_id_o), 64'(e.id));
            chk("rsp_rdata", rsp_rdata_o, e.data);
         end else begin
            chk("stray_rsp_valid", 64'(rsp_valid_o), 64'd0);
         end
      end else begin
         chk("idle_rsp_valid", 64'(rsp_valid_o), 64'd0);
      end
      for (int k = 0; k < NP; k++) begin
         if (req_ready_o[k]) begin
            accepted[k] = 1'b1;
            grant_log.push_back(k);
            chk("grant_addr", dc_req_addr_o, addr_d[k]);
            chk("grant_we", 64'(dc_req_we_o), 64'(we_d[k]));
            e.port = 32'(k);
            e.id   = id_d[k];
            e.data = dfn(addr_d[k], we_d[k]);
            sb.push_back(e);
         end
      end
      if (dc_req_valid_o && dc_req_ready_i) dcq.push_back(dfn(dc_req_addr_o, dc_req_we_o));
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      refill();
      dc_rsp_valid_i = 1'b0;
      dc_rsp_rdata_i = '0;
      if ((rsp_auto || rsp_once) && dcq.size() > 0) begin
         dc_rsp_valid_i = 1'b1;
         dc_rsp_rdata_i = dcq[0];
         rsp_once       = 1'b0;
      end
   endtask

   task automatic step();
      tick();
      advance();
   endtask

   task automatic clear_bench();
      req_valid_i    = '0;
      dc_rsp_valid_i = 1'b0;
      dc_rsp_rdata_i = '0;
      rsp_auto       = 1'b0;
      rsp_once       = 1'b0;
      accepted       = '0;
      sb.delete();
      dcq.delete();
      pq0.delete();
      pq1.delete();
      grant_log.delete();
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      clear_bench();
      dc_req_ready_i = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      int c;
      rsp_auto = 1'b1;
      c = 0;
      while (c < 200 && (sb.size() > 0 || pq0.size() > 0 || pq1.size() > 0 || req_valid_i != '0)) begin
         step();
         c++;
      end
      chk(tag, 64'(sb.size() + pq0.size() + pq1.size()), 64'd0);
      rsp_auto = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int c0;
      req_t r;
      n_checks = 0;
      n_errors = 0;
      for (int k = 0; k < NP; k++) begin
         addr_d[k] = '0;
         id_d[k]   = '0;
         we_d[k]   = 1'b0;
      end

      // Outputs held low while reset is active, even with requests pending
      rstn = 1'b0;
      clear_bench();
      dc_req_ready_i = 1'b1;
      req_valid_i    = '1;
      #2;
      chk("reset_req_ready", 64'(req_ready_o), 64'd0);
      chk("reset_dc_valid", 64'(dc_req_valid_o), 64'd0);
      chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
      chk("reset_err", 64'(err_o), 64'd0);
      do_reset();

      // Ordered reads from port 0
      dc_req_ready_i = 1'b1;
      pq0.push_back('{addr: 64'h1000, id: 4'd1, we: 1'b0});
      pq0.push_back('{addr: 64'h2008, id: 4'd2, we: 1'b0});
      refill();
      repeat (3) step();
      chk("ordered_grants", 64'(grant_log.size()), 64'd2);
      drain("ordered_drain");

      // Fairness with both ports streaming, mixed reads and writes
      do_reset();
      dc_req_ready_i = 1'b1;
      rsp_auto       = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pq0.push_back('{addr: 64'h4000 + 64'(i * 8), id: 4'(i), we: 1'(i % 2)});
         pq1.push_back('{addr: 64'h8000 + 64'(i * 8), id: 4'(8 + i), we: 1'b0});
      end
      refill();
      drain("fair_drain");
      chk("fair_total", 64'(grant_log.size()), 64'd8);
      c0 = 0;
      for (int i = 0; i < grant_log.size(); i++) begin
         chk("fair_order", 64'(grant_log[i]), 64'(i % 2));
         if (grant_log[i] == 0) c0++;
      end
      chk("fair_port0_count", 64'(c0), 64'd4);

      // Lock under backpressure: port 1 stays presented while port 0 arrives
      do_reset();
      pq1.push_back('{addr: 64'hB100, id: 4'd3, we: 1'b0});
      refill();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("lock_addr", dc_req_addr_o, 64'hB100);
         chk("lock_ready", 64'(req_ready_o), 64'd0);
         if (i == 0) pq0.push_back('{addr: 64'hA000, id: 4'd5, we: 1'b0});
         advance();
      end
      dc_req_ready_i = 1'b1;
      tick();
      chk("lock_release", 64'(req_ready_o), 64'b10);
      advance();
      tick();
      chk("lock_next_grant", 64'(req_ready_o), 64'b01);
      advance();
      drain("lock_drain");

      // Full FIFO, no same-cycle bypass, then push+pop at count 3 with pointer wrap
      do_reset();
      dc_req_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         pq0.push_back('{addr: 64'hC000 + 64'(i * 16), id: 4'(i), we: 1'(i == 6)});
      end
      refill();
      repeat (4) step();
      tick();
      chk("full_dc_valid", 64'(dc_req_valid_o), 64'd0);
      chk("full_req_ready", 64'(req_ready_o), 64'd0);
      rsp_once = 1'b1;
      advance();
      tick();
      chk("no_bypass", 64'(dc_req_valid_o), 64'd0);
      rsp_auto = 1'b1;
      advance();
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("pushpop_issue", 64'(dc_req_valid_o), 64'd1);
         advance();
      end
      drain("wrap_drain");

      // Unexpected response with nothing outstanding
      do_reset();
      dc_rsp_valid_i = 1'b1;
      dc_rsp_rdata_i = 64'hDEAD_BEEF;
      tick();
      advance();
      tick();
      chk("err_set", 64'(err_o), 64'd1);
      advance();
      repeat (3) step();
      chk("err_sticky", 64'(err_o), 64'd1);

      // Reset in the middle of traffic, then a late dcache response
      dc_req_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pq0.push_back('{addr: 64'hE000 + 64'(i * 8), id: 4'(i), we: 1'b0});
         pq1.push_back('{addr: 64'hF000 + 64'(i * 8), id: 4'(i), we: 1'b0});
      end
      refill();
      repeat (2) step();
      rstn = 1'b0;
      #1;
      chk("midrst_req_ready", 64'(req_ready_o), 64'd0);
      chk("midrst_dc_valid", 64'(dc_req_valid_o), 64'd0);
      chk("midrst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      chk("midrst_err", 64'(err_o), 64'd0);
      clear_bench();
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      dc_rsp_valid_i = 1'b1;
      dc_rsp_rdata_i = 64'h1234;
      tick();
      advance();
      tick();
      chk("late_rsp_err", 64'(err_o), 64'd1);
      advance();
      r = '{addr: 64'h9990, id: 4'd7, we: 1'b0};
      pq1.push_back(r);
      refill();
      drain("post_reset_drain");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/xadac_dcache_mux.md
Name: xadac_dcache_mux

Overview:
Parametrised N-port successor to the single-master AXI-to-dcache adaptation path. It arbitrates up to NumPorts simple valid/ready memory requesters (vector unit, narrow AXI adapter, future accelerators) onto one dcache-style request port. It tracks up to MaxOutstanding in-flight requests in an in-order ID FIFO and routes each in-order dcache response back to the requester that issued it.

Parameters:
NumPorts, 2, number of requester ports (>=1; 1 = pass-through with tracking)
AddrWidth, 64, request address width
DataWidth, 64, data width; byte-enable width is DataWidth/8
IdWidth, 4, per-requester transaction ID, echoed on the response
MaxOutstanding, 4, tracking FIFO depth (>=1; need not be a power of two)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid_i  in  NumPorts  per-port request valid
req_ready_o  out  NumPorts  per-port request accepted
req_addr_i  in  NumPorts*AddrWidth  request address
req_wdata_i  in  NumPorts*DataWidth  write data
req_be_i  in  NumPorts*DataWidth/8  byte enables
req_we_i  in  NumPorts  1 = write, 0 = read
req_id_i  in  NumPorts*IdWidth  requester transaction ID
rsp_valid_o  out  NumPorts  response strobe; no backpressure, requester must accept
rsp_rdata_o  out  DataWidth  read data, shared by all ports
rsp_id_o  out  IdWidth  ID echoed from the matching request
dc_req_valid_o  out  1  downstream request valid
dc_req_ready_i  in  1  downstream grant
dc_req_addr_o  out  AddrWidth  downstream address
dc_req_wdata_o  out  DataWidth  downstream write data
dc_req_be_o  out  DataWidth/8  downstream byte enables
dc_req_we_o  out  1  downstream write enable
dc_rsp_valid_i  in  1  in-order response strobe; write acks included
dc_rsp_rdata_i  in  DataWidth  response data
err_o  out  1  sticky protocol error

Behaviour:
- Clock and reset: single clock clk. Reset rstn is asynchronous and active-low. While rstn=0, all state clears: FIFO empty, count=0, rr_ptr=0, lock cleared, err_o=0.
- Reset outputs: req_ready_o, rsp_valid_o and dc_req_valid_o are all 0 during reset. Data outputs are don't-care.
- Issue gate: a request may issue only when count < MaxOutstanding. There is no same-cycle bypass of a response pop.
- Arbitration: combinational round-robin. Search starts at rr_ptr and wraps modulo NumPorts. The first port with req_valid_i=1 wins.
- Request path: dc_req_valid_o = winner exists AND issue allowed. dc_req_* fields are muxed from the winner with zero latency.
- Lock: if dc_req_valid_o=1 and dc_req_ready_i=0, the winner index is locked. The same port is presented every cycle until the grant, even if a higher-priority port raises valid. Requesters must hold their fields stable while waiting.
- Accept handshake: req_ready_o[k] = dc_req_valid_o AND dc_req_ready_i AND winner==k.
- On accept:
  - push {k, req_id} into the FIFO;
  - rr_ptr <= (k+1) mod NumPorts;
  - clear the lock.
- Response routing: on dc_rsp_valid_i with count>0, pop the FIFO head {k,id}. Drive rsp_valid_o[k]=1, rsp_id_o=id, rsp_rdata_o=dc_rsp_rdata_i, all combinational with zero latency. Write acks are routed the same way.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap at MaxOutstanding-1 -> 0.
- Full FIFO (count==MaxOutstanding): dc_req_valid_o=0 and all req_ready_o=0. A pop in that cycle does not enable an issue until the next cycle.
- Unexpected response (dc_rsp_valid_i with count==0): no rsp_valid_o, err_o set. err_o clears only on reset.
- Reset mid-operation: outstanding transactions are dropped with no responses. Any late dcache responses then set err_o.
- Widths: count is $clog2(MaxOutstanding+1) bits. rr_ptr is max(1,$clog2(NumPorts)) bits.

Optional Feature:
Macro XADAC_DCACHE_MUX_PERF_EN.
- Defined, adds outputs:
  - perf_grant_cnt_o (NumPorts*32): per-port accepted-request counters.
  - perf_full_stall_cnt_o (32): counts cycles with any req_valid_i=1 and count==MaxOutstanding.
- Counter behaviour: all counters wrap at 2^32 and reset to 0.
- Not defined: ports and logic are absent, and functional behaviour is identical.

Test Plan:
- Ordered read responses: NumPorts=2, MaxOutstanding=4. Port0 issues reads id=1,2 back-to-back with dc_req_ready_i=1. Responses data A,B -> rsp_valid_o[0] pulses twice, rsp_id_o=1 then 2, rdata A then B.
- Fairness: ports 0 and 1 valid continuously, ready=1 -> grant order 0,1,0,1. After 8 accepts each port has 4.
- Lock under backpressure: port1 wins with ready=0 for 3 cycles while port0 raises valid. dc_req_addr_o stays port1's address. On ready, req_ready_o=2'b10, and the next grant goes to port0.
- Full FIFO: MaxOutstanding=4, 4 accepts with no responses -> dc_req_valid_o=0. One response -> issue resumes the following cycle, not the same cycle.
- Simultaneous push/pop at count=3 -> count stays 3. Wrap is exercised over 10 transactions with IDs 0..9 mod 16 returned correctly.
- Error and reset: dc_rsp_valid_i at count=0 -> err_o=1, no rsp_valid_o. Assert rstn mid-traffic -> outputs are 0 immediately, count=0, err_o=0.
